screen_draw_sequencer: RTL and testbench

SCREEN_DRAW_SEQUENCER -- requirements
Module: screen_draw_sequencer

---
 rtl/screen_draw_sequencer.sv | 117 +++++++++++
 tb/tb_screen_draw_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/screen_draw_sequencer.sv
// rtl/screen_draw_sequencer.sv - raster address sequencer that walks a full screen through a ROM and emits aligned plot strobes
module screen_draw_sequencer #(
    parameter int H_PIXELS    = 160,
    parameter int V_PIXELS    = 120,
    parameter int ROM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [6:0]  memorySelIn,
    input  logic        blackIn,
    output logic [14:0] screenCount,
    output logic [6:0]  memorySel,
    output logic        black,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam int LAST_ADDR = H_PIXELS * V_PIXELS - 1;

    state_t                          state;
    logic [7:0]                      xa;
    logic [6:0]                      ya;
    logic [1:0]                      drain_cnt;
    logic [ROM_LATENCY-1:0]          pv;
    logic [ROM_LATENCY-1:0][7:0]     px;
    logic [ROM_LATENCY-1:0][6:0]     py;

    assign plot = pv[ROM_LATENCY-1];
    assign x    = px[ROM_LATENCY-1];
    assign y    = py[ROM_LATENCY-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            screenCount <= '0;
            xa          <= '0;
            ya          <= '0;
            drain_cnt   <= '0;
            memorySel   <= '0;
            black       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pv          <= '0;
            px          <= '0;
            py          <= '0;
        end else begin
            // The pipeline mirrors the ROM plus colour register so x/y line up with colour.
            pv[0] <= (state == FETCH);
            px[0] <= xa;
            py[0] <= ya;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= FETCH;
                        busy        <= 1'b1;
                        screenCount <= '0;
                        xa          <= '0;
                        ya          <= '0;
                        memorySel   <= memorySelIn;
                        black       <= blackIn;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pv    <= '0;
                    end else if (screenCount == 15'(LAST_ADDR)) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'(ROM_LATENCY - 1);
                    end else begin
                        screenCount <= screenCount + 15'd1;
                        if (xa == 8'(H_PIXELS - 1)) begin
                            xa <= '0;
                            ya <= ya + 7'd1;
                        end else begin
                            xa <= xa + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    // One DRAIN cycle per pipeline stage still holding fetched pixels.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pv    <= '0;
                    end else if (drain_cnt == 2'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_draw_sequencer.sv
// tb/tb_screen_draw_sequencer.sv - randomized bench comparing three latency variants against a frame-timing model
module tb_screen_draw_sequencer;

    localparam int H = 160;
    localparam int V = 120;
    localparam int N = H * V;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [6:0] memorySelIn = '0;
    logic blackIn = 1'b0;

    logic [2:0][14:0] sc;
    logic [2:0][6:0]  msel;
    logic [2:0]       blk_o;
    logic [2:0][7:0]  xo;
    logic [2:0][6:0]  yo;
    logic [2:0]       plot_o;
    logic [2:0]       busy_o;
    logic [2:0]       done_o;

    int checks = 0;
    int failures = 0;

    int lat [3] = '{1, 2, 4};
    bit act [3] = '{0, 0, 0};
    int t   [3] = '{0, 0, 0};
    logic [6:0] sel [3] = '{7'd0, 7'd0, 7'd0};
    bit blk [3] = '{0, 0, 0};
    int pc  [3] = '{0, 0, 0};
    int frames = 0;

    always #5 clk = ~clk;

    screen_draw_sequencer #(.H_PIXELS(H), .V_PIXELS(V), .ROM_LATENCY(1)) dut_l1 (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .memorySelIn(memorySelIn), .blackIn(blackIn), .screenCount(sc[0]),
        .memorySel(msel[0]), .black(blk_o[0]), .x(xo[0]), .y(yo[0]),
        .plot(plot_o[0]), .busy(busy_o[0]), .done(done_o[0]));

    screen_draw_sequencer #(.H_PIXELS(H), .V_PIXELS(V), .ROM_LATENCY(2)) dut_l2 (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .memorySelIn(memorySelIn), .blackIn(blackIn), .screenCount(sc[1]),
        .memorySel(msel[1]), .black(blk_o[1]), .x(xo[1]), .y(yo[1]),
        .plot(plot_o[1]), .busy(busy_o[1]), .done(done_o[1]));

    screen_draw_sequencer #(.H_PIXELS(H), .V_PIXELS(V), .ROM_LATENCY(4)) dut_l4 (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .memorySelIn(memorySelIn), .blackIn(blackIn), .screenCount(sc[2]),
        .memorySel(msel[2]), .black(blk_o[2]), .x(xo[2]), .y(yo[2]),
        .plot(plot_o[2]), .busy(busy_o[2]), .done(done_o[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame model: t counts cycles since the accepted start edge; frame lasts N+L+1 cycles.
    always @(posedge clk or negedge resetn) begin
        for (int i = 0; i < 3; i++) begin
            if (!resetn) begin
                act[i] = 0;
                t[i]   = 0;
                sel[i] = '0;
                blk[i] = 0;
            end else if (act[i]) begin
                if (abort && t[i] <= N + lat[i]) act[i] = 0;
                else if (t[i] == N + lat[i] + 1) act[i] = 0;
                else t[i] = t[i] + 1;
            end else if (start) begin
                act[i] = 1;
                t[i]   = 1;
                sel[i] = memorySelIn;
                blk[i] = blackIn;
                if (i == 1) frames = frames + 1;
            end
        end
    end

    task automatic step();
        int l, k, a;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            l = lat[i];
            check($sformatf("msel%0d", l), 32'(msel[i]), 32'(sel[i]));
            check($sformatf("black%0d", l), 32'(blk_o[i]), 32'(blk[i]));
            if (act[i]) begin
                if (t[i] == 1) pc[i] = 0;
                check($sformatf("busy%0d", l), 32'(busy_o[i]), 32'(t[i] <= N + l));
                check($sformatf("done%0d", l), 32'(done_o[i]), 32'(t[i] == N + l + 1));
                if (t[i] <= N + l) begin
                    a = (t[i] - 1 < N - 1) ? t[i] - 1 : N - 1;
                    check($sformatf("addr%0d", l), 32'(sc[i]), 32'(a));
                end
                check($sformatf("plot%0d", l), 32'(plot_o[i]), 32'(t[i] >= l + 1 && t[i] <= N + l));
                if (t[i] >= l + 1 && t[i] <= N + l) begin
                    k = t[i] - l - 1;
                    check($sformatf("x%0d", l), 32'(xo[i]), 32'(k % H));
                    check($sformatf("y%0d", l), 32'(yo[i]), 32'(k / H));
                    if (plot_o[i]) pc[i]++;
                end
                if (t[i] == N + l + 1)
                    check($sformatf("plot_count%0d", l), 32'(pc[i]), 32'(N));
            end else begin
                check($sformatf("idle_plot%0d", l), 32'(plot_o[i]), 32'd0);
                check($sformatf("idle_busy%0d", l), 32'(busy_o[i]), 32'd0);
                check($sformatf("idle_done%0d", l), 32'(done_o[i]), 32'd0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_addr"}, 32'(sc[i]), 32'd0);
            check({tag, "_msel"}, 32'(msel[i]), 32'd0);
            check({tag, "_black"}, 32'(blk_o[i]), 32'd0);
            check({tag, "_x"}, 32'(xo[i]), 32'd0);
            check({tag, "_y"}, 32'(yo[i]), 32'd0);
            check({tag, "_plot"}, 32'(plot_o[i]), 32'd0);
            check({tag, "_busy"}, 32'(busy_o[i]), 32'd0);
            check({tag, "_done"}, 32'(done_o[i]), 32'd0);
        end
    endtask

    initial begin
        int n;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_hold");
        resetn = 1'b1;
        memorySelIn = 7'd5;
        blackIn = 1'b1;
        start = 1'b1;

        // Start held high: frame 1 then back-to-back frame 2 with fresh random selects.
        n = 0;
        while (!(frames == 2 && act[1] && t[1] == 5001) && n < 45000) begin
            step();
            memorySelIn = 7'($urandom);
            blackIn = 1'($urandom);
            n++;
        end
        check("reach_abort_point", 32'(n < 45000), 32'd1);

        abort = 1'b1;
        start = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            abort = 1'($urandom);
            memorySelIn = 7'($urandom);
            step();
        end
        abort = 1'b1;
        start = 1'b1;
        memorySelIn = 7'($urandom);
        step();
        abort = 1'b0;
        start = 1'b0;

        n = 0;
        while (!(act[1] && t[1] == N + 1) && n < 25000) begin
            step();
            memorySelIn = 7'($urandom);
            blackIn = 1'($urandom);
            n++;
        end
        check("reach_drain", 32'(n < 25000), 32'd1);

        #2 resetn = 1'b0;
        #1 check_all_zero("async_reset");
        step();
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
